// File: rtl/seq_detect_pkg.sv
// Shared types and constants for the time-multiplexed 1010110 sequence detector.
package seq_detect_pkg;

    // Detector context: Sn means the last n accepted bits match the first n
    // pattern bits. 3'b111 is unused and steps back to S0.
    typedef enum logic [2:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4,
        S5 = 3'd5,
        S6 = 3'd6
    } state_t;

    // The detected sequence, first bit in the MSB.
    localparam logic [6:0] PATTERN = 7'b1010110;

    // Saturating increment for the per-channel detection counters.
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic [31:0] max_value);
        return (value >= max_value) ? max_value : value + 32'd1;
    endfunction

endpackage

// File: rtl/seq_detect_step.sv
// One combinational step of the 1010110 Mealy detector (overlapping matches).
module seq_detect_step
    import seq_detect_pkg::*;
(
    input  state_t state,
    input  logic   bit_in,
    output state_t next_state,
    output logic   detect
);

    // Next-state and detect decode; the detect fires on the final 0 after S6.
    always_comb begin
        next_state = S0;
        detect     = 1'b0;
        case (state)
            S0: next_state = bit_in ? S1 : S0;
            S1: next_state = bit_in ? S1 : S2;
            S2: next_state = bit_in ? S3 : S0;
            S3: next_state = bit_in ? S1 : S4;
            S4: next_state = bit_in ? S5 : S0;
            S5: next_state = bit_in ? S6 : S4;
            S6: begin
                next_state = bit_in ? S1 : S2;
                detect     = ~bit_in;
            end
            default: begin
                next_state = S0;
                detect     = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/seq_detect_scheduler.sv
// Round-robin scheduler sharing one detector step across NUM_CH serial channels.
//
// Handshake: a channel offers a bit with ch_valid[i]; the scheduler accepts it
// only in a cycle where ch_ready[i] is also high (valid & ready = transfer).
// ch_ready is one-hot or zero, is computed from valid/clear/enable and the
// round-robin pointer only (never from ch_bit), and valid may be held or
// dropped freely by the channel without affecting other channels.
module seq_detect_scheduler
    import seq_detect_pkg::*;
#(
    parameter  int NUM_CH = 4,
    parameter  int CNT_W  = 8,
    localparam int CH_W   = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [NUM_CH-1:0] ch_valid,
    input  logic [NUM_CH-1:0] ch_bit,
    output logic [NUM_CH-1:0] ch_ready,
    input  logic [NUM_CH-1:0] ch_clear,
    output logic              det_valid,
    output logic [CH_W-1:0]   det_ch,
    input  logic [CH_W-1:0]   cnt_sel,
    output logic [CNT_W-1:0]  cnt_out
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Per-channel saved detector context and detection counters.
    state_t           ctx [NUM_CH];
    logic [CNT_W-1:0] cnt [NUM_CH];
    logic [CH_W-1:0]  ptr;

    logic [NUM_CH-1:0] eligible;
    logic              grant_found;
    logic [CH_W-1:0]   grant_idx;
    logic              transfer;
    state_t            step_state;
    state_t            step_next;
    logic              step_bit;
    logic              step_detect;

    // Channels that may be granted this cycle; a clearing channel is excluded.
    always_comb begin
        eligible = enable ? (ch_valid & ~ch_clear) : '0;
    end

    // Round-robin search starting at ptr and wrapping back to channel 0.
    always_comb begin
        int idx;
        grant_found = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = (int'(ptr) + k) % NUM_CH;
            if (!grant_found && eligible[CH_W'(idx)]) begin
                grant_found = 1'b1;
                grant_idx   = CH_W'(idx);
            end
        end
    end

    // One-hot grant, forced low while reset is held.
    always_comb begin
        ch_ready = '0;
        if (reset && grant_found) begin
            ch_ready = NUM_CH'(1) << grant_idx;
        end
    end

    // Transfer qualifier and the shared-step input mux.
    always_comb begin
        transfer   = |(ch_valid & ch_ready);
        step_state = ctx[grant_idx];
        step_bit   = ch_bit[grant_idx];
    end

    seq_detect_step u_step (
        .state      (step_state),
        .bit_in     (step_bit),
        .next_state (step_next),
        .detect     (step_detect)
    );

    // Context, counter and pointer update for the granted and cleared channels.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                ctx[i] <= S0;
                cnt[i] <= '0;
            end
            ptr <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (ch_clear[i]) begin
                    ctx[i] <= S0;
                    cnt[i] <= '0;
                end else if (transfer && (grant_idx == CH_W'(i))) begin
                    ctx[i] <= step_next;
                    if (step_detect && (cnt[i] != CNT_MAX)) begin
                        cnt[i] <= cnt[i] + CNT_W'(1);
                    end
                end
            end
            if (transfer) begin
                ptr <= CH_W'((int'(grant_idx) + 1) % NUM_CH);
            end
        end
    end

    // Registered detection pulse tagged with the detecting channel.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            det_valid <= 1'b0;
            det_ch    <= '0;
        end else begin
            det_valid <= transfer & step_detect;
            det_ch    <= (transfer & step_detect) ? grant_idx : '0;
        end
    end

    // Combinational counter read; out-of-range selects read as zero.
    always_comb begin
        cnt_out = '0;
        if (int'(cnt_sel) < NUM_CH) begin
            cnt_out = cnt[cnt_sel];
        end
    end

endmodule

// File: tb/tb_seq_detect_scheduler.sv
// Bench for seq_detect_scheduler: directed scenarios plus biased random traffic
// against a history-based reference model (last seven accepted bits per channel).
module tb_seq_detect_scheduler;

  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;
  localparam int MAX8   = 255;
  localparam int MAX2   = 3;

  logic              clk;
  logic              reset;
  logic              enable;
  logic [NUM_CH-1:0] ch_valid;
  logic [NUM_CH-1:0] ch_bit;
  logic [NUM_CH-1:0] ch_clear;
  logic [CH_W-1:0]   cnt_sel;

  logic [NUM_CH-1:0] ch_ready;
  logic              det_valid;
  logic [CH_W-1:0]   det_ch;
  logic [7:0]        cnt_out;

  logic [NUM_CH-1:0] ch_ready_s;
  logic              det_valid_s;
  logic [CH_W-1:0]   det_ch_s;
  logic [1:0]        cnt_out_s;

  int checks_cnt = 0;
  int errors_cnt = 0;

  // scoreboard: expected detecting channels, one entry per predicted pulse
  logic [CH_W-1:0] exp_q[$];

  // reference model state
  int         m_ptr;
  logic [6:0] m_hist [NUM_CH];
  int         m_len  [NUM_CH];
  int         m_cnt  [NUM_CH];
  logic [6:0] pat_v;

  seq_detect_scheduler #(.NUM_CH(NUM_CH), .CNT_W(8)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .ch_valid  (ch_valid),
    .ch_bit    (ch_bit),
    .ch_ready  (ch_ready),
    .ch_clear  (ch_clear),
    .det_valid (det_valid),
    .det_ch    (det_ch),
    .cnt_sel   (cnt_sel),
    .cnt_out   (cnt_out)
  );

  // narrow-counter instance sharing the same stimulus, for saturation
  seq_detect_scheduler #(.NUM_CH(NUM_CH), .CNT_W(2)) u_sat (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .ch_valid  (ch_valid),
    .ch_bit    (ch_bit),
    .ch_ready  (ch_ready_s),
    .ch_clear  (ch_clear),
    .det_valid (det_valid_s),
    .det_ch    (det_ch_s),
    .cnt_sel   (cnt_sel),
    .cnt_out   (cnt_out_s)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int m);
    return (v > m) ? m : v;
  endfunction

  function automatic int model_grant(input logic [NUM_CH-1:0] v, input logic [NUM_CH-1:0] c,
                                     input logic en);
    int idx;
    if (!en) return -1;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = (m_ptr + k) % NUM_CH;
      if (v[idx] && !c[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      m_hist[i] = '0;
      m_len[i]  = 0;
      m_cnt[i]  = 0;
    end
    exp_q.delete();
  endtask

  // reset driver: hold reset low for one full cycle with traffic offered
  task automatic apply_reset();
    reset    = 1'b0;
    enable   = 1'b1;
    ch_valid = '1;
    ch_bit   = '1;
    ch_clear = '0;
    cnt_sel  = CH_W'($urandom_range(0, NUM_CH - 1));
    model_reset();
    @(negedge clk);
    check("rst_ready", 32'(ch_ready), 32'd0);
    check("rst_det_valid", 32'(det_valid), 32'd0);
    check("rst_det_ch", 32'(det_ch), 32'd0);
    check("rst_cnt", 32'(cnt_out), 32'd0);
    check("rst_cnt_sat", 32'(cnt_out_s), 32'd0);
    @(posedge clk);
    #1;
    reset    = 1'b1;
    ch_valid = '0;
  endtask

  // one clock of stimulus; checks happen mid-cycle, model advances at the edge
  task automatic cycle(input logic [NUM_CH-1:0] v, input logic [NUM_CH-1:0] b,
                       input logic [NUM_CH-1:0] c, input logic en,
                       input logic [CH_W-1:0] sel, output int g);
    logic [NUM_CH-1:0] exp_ready;
    logic [CH_W-1:0]   d;
    ch_valid = v;
    ch_bit   = b;
    ch_clear = c;
    enable   = en;
    cnt_sel  = sel;
    @(negedge clk);
    g = model_grant(v, c, en);
    exp_ready = (g >= 0) ? (NUM_CH'(1) << g) : '0;
    check("ch_ready", 32'(ch_ready), 32'(exp_ready));
    check("ch_ready_sat", 32'(ch_ready_s), 32'(exp_ready));
    if (exp_q.size() > 0) begin
      d = exp_q.pop_front();
      check("det_valid", 32'(det_valid), 32'd1);
      check("det_ch", 32'(det_ch), 32'(d));
    end else begin
      check("det_valid", 32'(det_valid), 32'd0);
    end
    check("cnt_out", 32'(cnt_out), 32'(sat(m_cnt[sel], MAX8)));
    check("cnt_out_sat", 32'(cnt_out_s), 32'(sat(m_cnt[sel], MAX2)));
    for (int i = 0; i < NUM_CH; i++) begin
      if (c[i]) begin
        m_hist[i] = '0;
        m_len[i]  = 0;
        m_cnt[i]  = 0;
      end
    end
    if (g >= 0) begin
      m_hist[g] = {m_hist[g][5:0], b[g]};
      m_len[g]++;
      if (m_len[g] >= 7 && m_hist[g] == pat_v) begin
        m_cnt[g]++;
        exp_q.push_back(CH_W'(g));
      end
      m_ptr = (g + 1) % NUM_CH;
    end
    @(posedge clk);
    #1;
  endtask

  // feed n bits (MSB first of 'bits') to one channel, only that channel valid
  task automatic feed(input int ch, input logic [15:0] bits, input int n);
    int g;
    for (int k = n - 1; k >= 0; k--) begin
      cycle(NUM_CH'(1) << ch, bits[k] ? (NUM_CH'(1) << ch) : '0, '0, 1'b1, CH_W'(ch), g);
    end
  endtask

  task automatic idle(input int n, input int sel);
    int g;
    for (int k = 0; k < n; k++) cycle('0, '0, '0, 1'b1, CH_W'(sel), g);
  endtask

  initial begin
    int g;
    int pos [NUM_CH];
    logic [NUM_CH-1:0] v, b, c;
    logic en;

    pat_v    = 7'b1010110;
    reset    = 1'b0;
    enable   = 1'b0;
    ch_valid = '0;
    ch_bit   = '0;
    ch_clear = '0;
    cnt_sel  = '0;
    apply_reset();

    // single channel latency
    feed(0, 16'b1010110, 7);
    idle(1, 0);

    // overlap on ch1: 1010110 then 10110
    feed(1, 16'b1010110, 7);
    feed(1, 16'b10110, 5);
    idle(1, 1);

    // interleaved channels, all valid, each fed the pattern
    apply_reset();
    for (int i = 0; i < NUM_CH; i++) pos[i] = 0;
    for (int k = 0; k < 7 * NUM_CH + 1; k++) begin
      v = '0;
      b = '0;
      for (int i = 0; i < NUM_CH; i++) begin
        if (pos[i] < 7) begin
          v[i] = 1'b1;
          b[i] = pat_v[6 - pos[i]];
        end
      end
      cycle(v, b, '0, 1'b1, CH_W'(k % NUM_CH), g);
      if (g >= 0) pos[g]++;
    end
    idle(NUM_CH, 0);

    // clear during a pattern on ch2
    feed(2, 16'b101011, 6);
    cycle(4'b0100, 4'b0100, 4'b0100, 1'b1, 2'd2, g);
    feed(2, 16'b0, 1);
    idle(1, 2);

    // saturation on ch0: five overlapping detections
    apply_reset();
    feed(0, 16'b1010110, 7);
    for (int k = 0; k < 4; k++) feed(0, 16'b10110, 5);
    idle(1, 0);

    // enable low mid-pattern
    feed(3, 16'b1010, 4);
    for (int k = 0; k < 3; k++) cycle(4'b1000, 4'b1000, '0, 1'b0, 2'd3, g);
    feed(3, 16'b110, 3);
    idle(1, 3);

    // reset mid-pattern loses the partial match
    feed(0, 16'b101011, 6);
    apply_reset();
    feed(0, 16'b0, 1);
    idle(1, 0);

    // biased random traffic
    for (int i = 0; i < NUM_CH; i++) pos[i] = 0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 399) == 0) begin
        apply_reset();
        for (int i = 0; i < NUM_CH; i++) pos[i] = 0;
      end
      for (int i = 0; i < NUM_CH; i++) begin
        v[i] = ($urandom_range(0, 3) != 0);
        b[i] = ($urandom_range(0, 5) == 0) ? 1'($urandom_range(0, 1)) : pat_v[6 - pos[i]];
        c[i] = ($urandom_range(0, 59) == 0);
        if (c[i]) pos[i] = 0;
      end
      en = ($urandom_range(0, 9) != 0);
      cycle(v, b, c, en, CH_W'($urandom_range(0, NUM_CH - 1)), g);
      if (g >= 0) pos[g] = (pos[g] + 1) % 7;
    end
    idle(2, 0);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule

// File: doc/seq_detect_scheduler.md
Name: seq_detect_scheduler

Overview:
Time-multiplexes one 1010110 Mealy detector step across NUM_CH independent serial bit channels. Each channel has its own saved 3-bit detector context. A round-robin arbiter grants one channel per cycle, and only the granted channel's bit advances that channel's context. Detections are reported as a registered pulse tagged with the channel number, and each channel keeps a saturating detection counter that is read through a select port.

Parameters:
- NUM_CH, 4, number of serial channels (2..16)
- CNT_W, 8, width of each per-channel detection counter
- CH_W, $clog2(NUM_CH), width of a channel index (derived; do not override)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- enable  in  1  global grant enable; when low, no transfers occur
- ch_valid  in  NUM_CH  per-channel "bit available"
- ch_bit  in  NUM_CH  per-channel serial bit
- ch_ready  out  NUM_CH  one-hot grant; a transfer happens when valid & ready
- ch_clear  in  NUM_CH  synchronous per-channel context and counter clear
- det_valid  out  1  one-cycle detection pulse
- det_ch  out  CH_W  channel that detected; valid only with det_valid
- cnt_sel  in  CH_W  counter read select
- cnt_out  out  CNT_W  counter value of channel cnt_sel (combinational read)

Behaviour:
- Reset (reset=0, async):
  - all contexts = S0, all counters = 0, rr pointer = 0
  - det_valid = 0, det_ch = 0
  - ch_ready = 0 while reset is asserted
- Eligible set: ch_valid[i] & ~ch_clear[i], and only when enable=1.
- Arbitration:
  - combinational round-robin search starting at index ptr, wrapping at NUM_CH-1 to 0
  - ch_ready is one-hot or all-zero and never depends on ch_bit
- Pointer update:
  - on a transfer from channel g, ptr <= (g+1) mod NUM_CH
  - with no transfer, ptr holds
- Context step for the granted channel g (ctx[g] <= next):
  - S0: 1→S1, 0→S0
  - S1: 1→S1, 0→S2
  - S2: 1→S3, 0→S0
  - S3: 1→S1, 0→S4
  - S4: 1→S5, 0→S0
  - S5: 1→S6, 0→S4
  - S6: 1→S1, 0→S2 and detect
  - unused encodings (3'b111) → S0, no detect
- Overlap: after a detection the context goes to S2, so overlapping patterns are detected.
- Detection output:
  - det_valid <= transfer & detect; det_ch <= g
  - latency is 1 cycle after the bit transfer (registered)
  - det_valid = 0 in every cycle with no detecting transfer
- Counters:
  - cnt[g] increments on a detect and saturates at 2^CNT_W-1 with no wrap
- Clear:
  - ch_clear[i]=1 forces ctx[i] <= S0 and cnt[i] <= 0 next edge
  - it also masks ch_ready[i] in the same cycle, so clear and transfer never coincide on one channel
  - other channels are unaffected and can transfer in that cycle
- Non-granted channels: context and counter hold.
- enable=0: ch_ready all 0; contexts, counters and ptr hold; a detect registered in the prior cycle still pulses.
- Reset mid-pattern: context returns to S0 and the partial pattern is lost; no det_valid is produced from the pre-reset context.

Decomposition:
- Package seq_detect_pkg:
  - state typedef (3-bit) with S0..S6 constants
  - PATTERN constant 7'b1010110
- Sub-module seq_detect_step:
  - purely combinational (state, bit) → (next_state, detect)
  - instantiated once and shared through the grant mux
- The round-robin arbiter stays inline in seq_detect_scheduler.

Test Plan:
- Single channel, detection latency: only ch0 valid, bits 1,0,1,0,1,1,0 → det_valid one cycle after the 7th transfer, det_ch=0, cnt_out(sel=0)=1.
- Overlap: ch1 stream 1010110 followed by 10110 → two detections, cnt[1]=2. The second detection needs only 5 extra bits.
- Interleaving, round robin, context isolation:
  - all 4 channels valid every cycle, each fed 1010110
  - grants go 0,1,2,3,0,...
  - each channel detects exactly once; det_ch sequence 0,1,2,3 on consecutive cycles after the 7th round
- Clear during a pattern:
  - ch2 fed 101011, then ch_clear[2] pulses while ch2 is valid → ch_ready[2]=0 that cycle
  - then bit 0 → no detect, ctx[2]=S0, cnt[2]=0
- Saturation: CNT_W=2, ch0 detects 5 times → cnt_out=3.
- enable/reset:
  - enable=0 for 3 cycles mid-pattern → no ready, pattern resumes and detects on completion
  - asserting reset after 101011 then feeding 0 → no det_valid
